// File: rtl/serial_operand_feeder_pkg.sv
// Shared types and defaults for the serial operand feeder that drives the bit-serial adder.
package serial_pkg;
  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_e;
  localparam int DEFAULT_WIDTH = 16;
endpackage

// File: rtl/serial_operand_feeder_if.sv
// Operand handshake on the parallel side plus the framed bit-serial stream towards the adder.
interface serial_operand_feeder_if import serial_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             ser_ready;
  logic             ser_valid;
  logic             ser_a;
  logic             ser_b;
  logic             ser_first;
  logic             ser_last;

  // master is the feeder itself; slave is the operand source plus downstream adder
  modport master (
    input  in_valid, in_a, in_b, ser_ready,
    output in_ready, ser_valid, ser_a, ser_b, ser_first, ser_last
  );

  modport slave (
    output in_valid, in_a, in_b, ser_ready,
    input  in_ready, ser_valid, ser_a, ser_b, ser_first, ser_last
  );
endinterface

// File: rtl/serial_operand_feeder_piso_shift_reg.sv
// Parallel-in serial-out register, LSB first, zero fill; load wins over shift.
module piso_shift_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] par_in,
  output logic             ser_out
);
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_d;

  always_comb begin
    sh_d = sh_q;
    if (load) begin
      sh_d = par_in;
    end else if (shift_en) begin
      sh_d = {1'b0, sh_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q <= '0;
    end else begin
      sh_q <= sh_d;
    end
  end

  assign ser_out = sh_q[0];
endmodule

// File: rtl/serial_operand_feeder.sv
// Accepts operand pairs and streams them LSB-first with first/last framing for the serial adder.
module serial_operand_feeder import serial_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  serial_operand_feeder_if.master bus,
  output logic                    busy
);
  localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load, shift_en, rdy, last_beat;
  logic             bit_a, bit_b;
  logic             in_shift;

  assign in_shift  = (state_q == SHIFT);
  assign last_beat = in_shift && (cnt_q == LAST_CNT);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load     = 1'b0;
    shift_en = 1'b0;
    rdy      = 1'b0;
    case (state_q)
      IDLE: begin
        rdy = 1'b1;
        if (bus.in_valid) begin
          load    = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // The last beat doubles as the load slot so back-to-back frames have no bubble
        rdy = last_beat && bus.ser_ready;
        if (bus.ser_ready) begin
          if (last_beat) begin
            cnt_d = '0;
            if (bus.in_valid) begin
              load = 1'b1;
            end else begin
              shift_en = 1'b1;
              state_d  = IDLE;
            end
          end else begin
            shift_en = 1'b1;
            cnt_d    = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  piso_shift_reg #(.WIDTH(WIDTH)) u_sh_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .shift_en (shift_en),
    .par_in   (bus.in_a),
    .ser_out  (bit_a)
  );

  piso_shift_reg #(.WIDTH(WIDTH)) u_sh_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .shift_en (shift_en),
    .par_in   (bus.in_b),
    .ser_out  (bit_b)
  );

  assign bus.in_ready  = rdy;
  assign bus.ser_valid = in_shift;
  assign bus.ser_a     = in_shift & bit_a;
  assign bus.ser_b     = in_shift & bit_b;
  assign bus.ser_first = in_shift && (cnt_q == '0);
  assign bus.ser_last  = last_beat;
  assign busy          = in_shift;
endmodule

// File: tb/tb_serial_operand_feeder.sv
// Directed bench with a beat scoreboard for the serial operand feeder.
module tb_serial_operand_feeder;
  localparam int W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  serial_operand_feeder_if #(.WIDTH(W)) bus ();

  serial_operand_feeder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master),
    .busy  (busy)
  );

  int errors = 0;
  int checks = 0;
  int xfers  = 0;

  logic [3:0] exp_q[$];  // {first, last, a, b}
  logic       stall_prev = 1'b0;
  logic [4:0] held       = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops one expected beat per transfer, pushes a frame per accepted operand pair
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("stall_hold", {27'd0, bus.ser_valid, bus.ser_first, bus.ser_last, bus.ser_a, bus.ser_b},
              {27'd0, held});
      if (bus.ser_valid && bus.ser_ready) begin
        xfers++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'd1, 32'd0);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          check("beat", {28'd0, bus.ser_first, bus.ser_last, bus.ser_a, bus.ser_b}, {28'd0, e});
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        for (int i = 0; i < W; i++)
          exp_q.push_back({(i == 0), (i == W - 1), bus.in_a[i], bus.in_b[i]});
      end
      stall_prev = bus.ser_valid && !bus.ser_ready;
      held       = {bus.ser_valid, bus.ser_first, bus.ser_last, bus.ser_a, bus.ser_b};
    end
  end

  task automatic load_pair(input logic [W-1:0] a, input logic [W-1:0] b);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("load_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    check({tag, "_ser_out"},
          {27'd0, bus.ser_valid, bus.ser_a, bus.ser_b, bus.ser_first, bus.ser_last}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int base;
    int pulses;
    int wait_cnt;
    logic [3:0] ab_a;
    logic [3:0] ab_b;

    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.ser_ready = 1'b1;

    // 1: reset state
    #2;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 2: single frame 0005 / 0003, latency and framing
    ab_a = 4'b0101;
    ab_b = 4'b0011;
    load_pair(16'h0005, 16'h0003);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      check("t2_valid", {31'd0, bus.ser_valid}, 32'd1);
      check("t2_first", {31'd0, bus.ser_first}, (k == 0) ? 32'd1 : 32'd0);
      check("t2_last",  {31'd0, bus.ser_last},  (k == W - 1) ? 32'd1 : 32'd0);
      if (k < 4) begin
        check("t2_ser_a", {31'd0, bus.ser_a}, {31'd0, ab_a[k]});
        check("t2_ser_b", {31'd0, bus.ser_b}, {31'd0, ab_b[k]});
      end
    end
    @(negedge clk);
    check("t2_done_valid", {31'd0, bus.ser_valid}, 32'd0);
    check("t2_done_ready", {31'd0, bus.in_ready}, 32'd1);

    // 3: back-to-back frames with in_valid held
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_a     = 16'hFFFF;
    bus.in_b     = 16'h0001;
    @(negedge clk);
    check("t3_accept", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_a = 16'hA5A5;
    bus.in_b = 16'h5A5A;
    pulses = 0;
    for (int k = 0; k < 2 * W; k++) begin
      @(negedge clk);
      check("t3_contig_valid", {31'd0, bus.ser_valid}, 32'd1);
      check("t3_in_ready", {31'd0, bus.in_ready}, (k == W - 1 || k == 2 * W - 1) ? 32'd1 : 32'd0);
      if (bus.in_ready) pulses++;
      if (k == W - 1) begin
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
      end
    end
    check("t3_pulses", pulses, 32'd2);
    @(negedge clk);
    check("t3_end_valid", {31'd0, bus.ser_valid}, 32'd0);

    // 4: three-cycle stall on beat 5
    base = xfers;
    load_pair(16'h1357, 16'h2468);
    repeat (4) @(posedge clk);
    #1;
    bus.ser_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      check("t4_stall_a", {31'd0, bus.ser_a}, 32'd1);
      check("t4_stall_b", {31'd0, bus.ser_b}, 32'd0);
      check("t4_stall_fl", {30'd0, bus.ser_first, bus.ser_last}, 32'd0);
      check("t4_stall_rdy", {31'd0, bus.in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    bus.ser_ready = 1'b1;
    wait_idle();
    check("t4_xfers", xfers - base, W);

    // 5: asynchronous reset mid-frame, then a fresh frame
    load_pair(16'h00FF, 16'h0F0F);
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t5_reset");
    @(negedge clk);
    check_reset_outputs("t5_reset_hold");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_no_partial", {31'd0, bus.ser_valid}, 32'd0);
    load_pair(16'h1234, 16'h0001);
    @(negedge clk);
    check("t5_first", {31'd0, bus.ser_first}, 32'd1);
    check("t5_bit0", {30'd0, bus.ser_a, bus.ser_b}, 32'd1);
    wait_idle();

    // 6: in_valid mid-frame is ignored until the last beat
    load_pair(16'hBEEF, 16'h0123);
    repeat (2) @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_a     = 16'hCAFE;
    bus.in_b     = 16'h7777;
    @(negedge clk);
    check("t6_ignored", {31'd0, bus.in_ready}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd1);
    wait_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      wait_cnt++;
      if (bus.in_ready) break;
    end
    check("t6_accept_beat", wait_cnt, 32'd13);
    check("t6_accept_last", {31'd0, bus.ser_last}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_idle();

    @(negedge clk);
    check("sb_empty", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
